bdd_walk_ctrl: RTL and testbench
================================

// Module: bdd_walk_ctrl
// PURPOSE
//  Sequencer for the decision-diagram accelerator. Walks one input feature vector from a root
//  node to a leaf class. Per node it reads node SRAM (coefficients + threshold) and child SRAM
//  (two 9-bit pointers), drives the shared MAC one term per cycle, compares acc to threshold and
//  follows the selected child. Sits between host start/done and the sram1/sram2/mac1 datapath.
// PARAMETERS
//  FEAT_W     8    width of one feature and one coefficient
//  NFEAT      3    features/coefficients per node (node word = (NFEAT+1)*FEAT_W bits)
//  ADDR_W     8    node/child SRAM address width; pointer width PTR_W = ADDR_W+1
//  ACC_W      18   MAC accumulator width (>= 2*FEAT_W + clog2(NFEAT))
//  MAX_DEPTH  255  node visits allowed before the walk aborts with err
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               reset, synchronous, active-low
//  start        in   1               1-cycle request; sampled only in IDLE
//  root_ptr     in   PTR_W           start pointer; bit ADDR_W = class flag
//  feat_in      in   NFEAT*FEAT_W    feature vector, feature k at [k*FEAT_W +: FEAT_W]; latched on start
//  busy         out  1               high from cycle after accepted start until done
//  done         out  1               1-cycle pulse, walk finished (class or err)
//  class_out    out  PTR_W           leaf pointer (flag bit set); held until next accepted start
//  err          out  1               with done: MAX_DEPTH exceeded; class_out = 0
//  node_addr    out  ADDR_W          node SRAM read address
//  node_rdata   in   (NFEAT+1)*FEAT_W  coefficients, coef k at [(NFEAT-k)*FEAT_W +: FEAT_W]; threshold in [FEAT_W-1:0]
//  child_addr   out  ADDR_W          child SRAM read address (== node_addr)
//  child_rdata  in   2*PTR_W         [2*PTR_W-1:PTR_W] = lo child (acc < thr), [PTR_W-1:0] = hi child
//  mac_clr      out  1               synchronous clear of MAC accumulator
//  mac_en       out  1               acc <= acc + mac_a*mac_b on next edge
//  mac_a        out  FEAT_W          feature operand
//  mac_b        out  FEAT_W          coefficient operand
//  mac_acc      in   ACC_W           registered MAC accumulator
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; busy, done, err, mac_clr, mac_en = 0; class_out,
//    node_addr, mac_a, mac_b = 0; depth = 0. Reset mid-walk abandons the walk, no done.
//  - SRAMs have 1-cycle registered read; controller never writes (write enables tied 0 outside).
//  - States: IDLE -> FETCH -> LOAD -> MAC(k=0..NFEAT-1) -> SETTLE -> DECIDE -> FETCH|DONE.
//    IDLE: on start latch feat_in, ptr=root_ptr, clear err. If root_ptr[ADDR_W]=1 -> DONE directly
//      (class_out=root_ptr, done next cycle, no SRAM/MAC activity).
//    FETCH: node_addr=child_addr=ptr[ADDR_W-1:0].
//    LOAD: rdata valid; latch coef/thr/children; mac_clr=1.
//    MAC: mac_en=1, mac_a=feat[k], mac_b=coef[k], NFEAT cycles.
//    SETTLE: wait one cycle for mac_acc.
//    DECIDE: next = (mac_acc < {0,thr}) ? lo : hi (unsigned). If next[ADDR_W]: class_out=next,
//      -> DONE. Else depth++; if depth==MAX_DEPTH -> DONE with err=1, class_out=0; else ptr=next, -> FETCH.
//    DONE: done=1 one cycle, busy=0, -> IDLE.
//  - Latency: NFEAT+4 cycles per internal node, +1 cycle DONE. NFEAT=3, depth d -> done at 7d+1
//    cycles after the start-accept edge.
//  - start while busy: ignored, no queueing. start in the DONE cycle is ignored; accepted from IDLE.
//  - Arithmetic unsigned; acc == thr selects hi child. A child pointing back to an ancestor is not
//    detected except by MAX_DEPTH.
//  - feat_in changes after accept do not affect the walk.
// STRUCTURE
//  - bdd_pkg: FEAT_W/ADDR_W/PTR_W defaults, state enum, node/child word field offsets, CLASS_BIT.
//  - Sub-module bdd_next_sel (combinational): mac_acc, thr, child word -> next ptr, is_class.
//  - MAC, SRAMs external; top-level instantiates this block alongside sram1, sram2, mac1.
// TESTING
//  - root_ptr=9'h105, start -> done 1 cycle later, class_out=9'h105, mac_en never asserted.
//  - Node0 coef=(1,2,3), thr=20, lo=9'h101, hi=9'h102; feat=(2,3,4): acc=20 -> class_out=9'h102 at cycle 8.
//  - Same node, feat=(1,1,1): acc=6 < 20 -> class_out=9'h101; mac_clr precedes 3 mac_en pulses.
//  - 3-level chain 0->5->9->leaf 9'h1AA -> done at cycle 22, node_addr sequence 0,5,9.
//  - Self-loop node0 hi=lo=9'h000, MAX_DEPTH=4 -> done with err=1, class_out=0 after 4 visits.
//  - rst_n low during MAC of 2nd node -> busy=0 next cycle, no done; new start then walks normally.

Source files
------------

// File: rtl/bdd_pkg.sv
// Shared defaults and the walk-state encoding for the decision-diagram sequencer.
package bdd_pkg;

    localparam int BDD_FEAT_W    = 8;
    localparam int BDD_NFEAT     = 3;
    localparam int BDD_ADDR_W    = 8;
    localparam int BDD_PTR_W     = BDD_ADDR_W + 1;
    localparam int BDD_ACC_W     = 18;
    localparam int BDD_MAX_DEPTH = 255;

    // Pointer bit that marks a leaf (class) instead of a node address.
    localparam int CLASS_BIT = BDD_ADDR_W;

    // Node word: coefficients above the threshold; child word: lo child above hi child.
    localparam int THR_LSB      = 0;
    localparam int COEF_LSB     = BDD_FEAT_W;
    localparam int CHILD_HI_LSB = 0;
    localparam int CHILD_LO_LSB = BDD_PTR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_MAC,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } bdd_state_e;

endpackage

// File: rtl/bdd_next_sel.sv
// Child selection: unsigned compare of the accumulator against the node threshold.
module bdd_next_sel #(
    parameter int ACC_W  = 18,
    parameter int FEAT_W = 8,
    parameter int PTR_W  = 9
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [FEAT_W-1:0]  thr_i,
    input  logic [2*PTR_W-1:0] child_i,
    output logic [PTR_W-1:0]   next_ptr_o,
    output logic               is_class_o
);

    logic take_lo;

    // Equality falls through to the hi child.
    assign take_lo    = acc_i < {{(ACC_W-FEAT_W){1'b0}}, thr_i};
    assign next_ptr_o = take_lo ? child_i[2*PTR_W-1:PTR_W] : child_i[PTR_W-1:0];
    assign is_class_o = next_ptr_o[PTR_W-1];

endmodule

// File: rtl/bdd_walk_ctrl.sv
// Walks one feature vector from a root pointer to a leaf class through node/child SRAMs
// and the shared MAC.
//   state    | meaning
//   S_IDLE   | waiting for start, feature vector latched on accept
//   S_FETCH  | node/child address presented to the SRAMs
//   S_LOAD   | read data valid, node latched, MAC cleared
//   S_MAC    | one multiply-accumulate term per cycle, NFEAT cycles
//   S_SETTLE | accumulator catching up with the last term
//   S_DECIDE | pick child, finish on leaf or depth limit, else next node
//   S_DONE   | raise done for one cycle, back to idle
module bdd_walk_ctrl
    import bdd_pkg::*;
#(
    parameter  int FEAT_W    = BDD_FEAT_W,
    parameter  int NFEAT     = BDD_NFEAT,
    parameter  int ADDR_W    = BDD_ADDR_W,
    parameter  int ACC_W     = BDD_ACC_W,
    parameter  int MAX_DEPTH = BDD_MAX_DEPTH,
    localparam int PTR_W     = ADDR_W + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [PTR_W-1:0]          root_ptr,
    input  logic [NFEAT*FEAT_W-1:0]   feat_in,
    output logic                      busy,
    output logic                      done,
    output logic [PTR_W-1:0]          class_out,
    output logic                      err,
    output logic [ADDR_W-1:0]         node_addr,
    input  logic [(NFEAT+1)*FEAT_W-1:0] node_rdata,
    output logic [ADDR_W-1:0]         child_addr,
    input  logic [2*PTR_W-1:0]        child_rdata,
    output logic                      mac_clr,
    output logic                      mac_en,
    output logic [FEAT_W-1:0]         mac_a,
    output logic [FEAT_W-1:0]         mac_b,
    input  logic [ACC_W-1:0]          mac_acc
);

    localparam int K_W     = (NFEAT > 1) ? $clog2(NFEAT) : 1;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    bdd_state_e                state_q;
    logic [K_W-1:0]            k_q;
    logic [K_W-1:0]            k_nxt;
    logic [DEPTH_W-1:0]        depth_q;
    logic [NFEAT*FEAT_W-1:0]   feat_q;
    logic [NFEAT*FEAT_W-1:0]   coef_q;
    logic [FEAT_W-1:0]         thr_q;
    logic [2*PTR_W-1:0]        child_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      err_q;
    logic [PTR_W-1:0]          class_q;
    logic [ADDR_W-1:0]         node_addr_q;
    logic                      mac_clr_q;
    logic                      mac_en_q;
    logic [FEAT_W-1:0]         mac_a_q;
    logic [FEAT_W-1:0]         mac_b_q;
    logic [FEAT_W-1:0]         feat_nxt;
    logic [FEAT_W-1:0]         coef_nxt;
    logic [PTR_W-1:0]          sel_ptr;
    logic                      sel_is_class;

    bdd_next_sel #(
        .ACC_W  (ACC_W),
        .FEAT_W (FEAT_W),
        .PTR_W  (PTR_W)
    ) u_next_sel (
        .acc_i      (mac_acc),
        .thr_i      (thr_q),
        .child_i    (child_q),
        .next_ptr_o (sel_ptr),
        .is_class_o (sel_is_class)
    );

    // coef_q keeps coefficient 0 in its top slot, mirroring the node word layout.
    assign k_nxt    = k_q + K_W'(1);
    assign feat_nxt = feat_q[int'(k_nxt)*FEAT_W +: FEAT_W];
    assign coef_nxt = coef_q[(NFEAT-1-int'(k_nxt))*FEAT_W +: FEAT_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            depth_q     <= '0;
            feat_q      <= '0;
            coef_q      <= '0;
            thr_q       <= '0;
            child_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            class_q     <= '0;
            node_addr_q <= '0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            mac_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        feat_q  <= feat_in;
                        err_q   <= 1'b0;
                        depth_q <= '0;
                        busy_q  <= 1'b1;
                        if (root_ptr[PTR_W-1]) begin
                            class_q <= root_ptr;
                            state_q <= S_DONE;
                        end else begin
                            class_q     <= '0;
                            node_addr_q <= root_ptr[ADDR_W-1:0];
                            state_q     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    mac_clr_q <= 1'b1;
                    state_q   <= S_LOAD;
                end
                S_LOAD: begin
                    coef_q   <= node_rdata[(NFEAT+1)*FEAT_W-1:FEAT_W];
                    thr_q    <= node_rdata[FEAT_W-1:0];
                    child_q  <= child_rdata;
                    k_q      <= '0;
                    mac_en_q <= 1'b1;
                    mac_a_q  <= feat_q[FEAT_W-1:0];
                    mac_b_q  <= node_rdata[NFEAT*FEAT_W +: FEAT_W];
                    state_q  <= S_MAC;
                end
                S_MAC: begin
                    if (k_q == K_W'(NFEAT-1)) begin
                        state_q <= S_SETTLE;
                    end else begin
                        k_q      <= k_nxt;
                        mac_en_q <= 1'b1;
                        mac_a_q  <= feat_nxt;
                        mac_b_q  <= coef_nxt;
                    end
                end
                S_SETTLE: begin
                    state_q <= S_DECIDE;
                end
                S_DECIDE: begin
                    if (sel_is_class) begin
                        class_q <= sel_ptr;
                        state_q <= S_DONE;
                    end else if (depth_q == DEPTH_W'(MAX_DEPTH-1)) begin
                        // A loop in the diagram ends here rather than spinning forever.
                        err_q   <= 1'b1;
                        class_q <= '0;
                        state_q <= S_DONE;
                    end else begin
                        depth_q     <= depth_q + DEPTH_W'(1);
                        node_addr_q <= sel_ptr[ADDR_W-1:0];
                        state_q     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign class_out  = class_q;
    assign node_addr  = node_addr_q;
    assign child_addr = node_addr_q;
    assign mac_clr    = mac_clr_q;
    assign mac_en     = mac_en_q;
    assign mac_a      = mac_a_q;
    assign mac_b      = mac_b_q;

endmodule

// File: tb/tb_bdd_walk_ctrl.sv
// Directed bench for bdd_walk_ctrl with behavioural SRAMs and MAC around it.
module tb_bdd_walk_ctrl;

    localparam int ACC_W = 18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  root_ptr;
    logic [23:0] feat_in;
    logic        busy, done, err;
    logic [8:0]  class_out;
    logic [7:0]  node_addr, child_addr;
    logic [31:0] node_rdata = '0;
    logic [17:0] child_rdata = '0;
    logic        mac_clr, mac_en;
    logic [7:0]  mac_a, mac_b;
    logic [ACC_W-1:0] mac_acc = '0;

    logic [31:0] node_mem [256];
    logic [17:0] child_mem [256];
    logic [7:0]  addr_q [$];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bdd_walk_ctrl #(.MAX_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .root_ptr   (root_ptr),
        .feat_in    (feat_in),
        .busy       (busy),
        .done       (done),
        .class_out  (class_out),
        .err        (err),
        .node_addr  (node_addr),
        .node_rdata (node_rdata),
        .child_addr (child_addr),
        .child_rdata(child_rdata),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_acc    (mac_acc)
    );

    always @(posedge clk) begin
        node_rdata  <= node_mem[node_addr];
        child_rdata <= child_mem[child_addr];
        if (mac_clr)     mac_acc <= '0;
        else if (mac_en) mac_acc <= mac_acc + mac_a * mac_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_node(input int a, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] thr,
                            input logic [8:0] lo, input logic [8:0] hi);
        node_mem[a]  = {c0, c1, c2, thr};
        child_mem[a] = {lo, hi};
    endtask

    // lat counts edges from the accept edge to the edge after which done is seen.
    task automatic run_walk(input logic [8:0] root, input logic [23:0] feat, input bit mid_start,
                            output int lat, output int n_en, output int n_clr,
                            output int clr_cyc, output int first_en);
        addr_q.delete();
        lat = -1; n_en = 0; n_clr = 0; clr_cyc = -1; first_en = -1;
        @(negedge clk);
        root_ptr = root; feat_in = feat; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feat_in = ~feat;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mid_start && c == 3) begin
                start = 1'b1;
                root_ptr = 9'h1EE;
            end
            if (mac_en) begin
                n_en++;
                if (first_en < 0) first_en = c;
            end
            if (mac_clr) begin
                n_clr++;
                if (clr_cyc < 0) clr_cyc = c;
                addr_q.push_back(node_addr);
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic load_chain();
        set_node(0, 8'd1, 8'd2, 8'd3, 8'd20, 9'h005, 9'h0FE);
        set_node(5, 8'd0, 8'd0, 8'd0, 8'd0, 9'h0FF, 9'h009);
        set_node(9, 8'd255, 8'd255, 8'd255, 8'd255, 9'h1BB, 9'h1AA);
    endtask

    initial begin
        int lat, n_en, n_clr, clr_cyc, first_en, n_done;
        for (int i = 0; i < 256; i++) begin
            node_mem[i]  = '0;
            child_mem[i] = '0;
        end
        rst_n = 1'b0; start = 1'b0; root_ptr = '0; feat_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_class", class_out, 0);
        chk("rst_node_addr", node_addr, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // leaf root
        run_walk(9'h105, 24'h0, 1'b0, lat, n_en, n_clr, clr_cyc, first_en);
        chk("leaf_lat", lat, 1);
        chk("leaf_class", class_out, 9'h105);
        chk("leaf_err", err, 0);
        chk("leaf_mac_en", n_en, 0);
        chk("leaf_mac_clr", n_clr, 0);
        @(posedge clk); #1;
        chk("leaf_done_pulse", done, 0);
        chk("leaf_busy", busy, 0);
        chk("leaf_class_hold", class_out, 9'h105);

        // single node, acc == thr picks hi
        set_node(0, 8'd1, 8'd2, 8'd3, 8'd20, 9'h101, 9'h102);
        run_walk(9'h000, {8'd4, 8'd3, 8'd2}, 1'b0, lat, n_en, n_clr, clr_cyc, first_en);
        chk("eq_lat", lat, 8);
        chk("eq_class", class_out, 9'h102);
        chk("eq_err", err, 0);
        chk("eq_mac_en", n_en, 3);

        // acc < thr picks lo; stray start mid-walk ignored
        run_walk(9'h000, {8'd1, 8'd1, 8'd1}, 1'b1, lat, n_en, n_clr, clr_cyc, first_en);
        chk("lo_lat", lat, 8);
        chk("lo_class", class_out, 9'h101);
        chk("lo_clr_cyc", clr_cyc, 1);
        chk("lo_first_en", first_en, 2);
        chk("lo_mac_en", n_en, 3);
        chk("lo_mac_clr", n_clr, 1);

        // one below threshold boundary
        set_node(0, 8'd1, 8'd2, 8'd3, 8'd21, 9'h101, 9'h102);
        run_walk(9'h000, {8'd4, 8'd3, 8'd2}, 1'b0, lat, n_en, n_clr, clr_cyc, first_en);
        chk("thr_m1_class", class_out, 9'h101);

        // three-level chain 0 -> 5 -> 9 -> 1AA
        load_chain();
        run_walk(9'h000, {8'd1, 8'd1, 8'd1}, 1'b0, lat, n_en, n_clr, clr_cyc, first_en);
        chk("chain_lat", lat, 22);
        chk("chain_class", class_out, 9'h1AA);
        chk("chain_mac_en", n_en, 9);
        chk("chain_nodes", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            chk("chain_addr0", addr_q[0], 8'h00);
            chk("chain_addr1", addr_q[1], 8'h05);
            chk("chain_addr2", addr_q[2], 8'h09);
        end

        // self-loop hits the depth limit
        set_node(0, 8'd1, 8'd1, 8'd1, 8'd0, 9'h000, 9'h000);
        run_walk(9'h000, {8'd1, 8'd1, 8'd1}, 1'b0, lat, n_en, n_clr, clr_cyc, first_en);
        chk("loop_lat", lat, 29);
        chk("loop_err", err, 1);
        chk("loop_class", class_out, 0);
        chk("loop_visits", n_clr, 4);

        // err cleared by the next accepted start
        run_walk(9'h105, 24'h0, 1'b0, lat, n_en, n_clr, clr_cyc, first_en);
        chk("post_err_err", err, 0);
        chk("post_err_class", class_out, 9'h105);

        // reset during MAC of the second node
        load_chain();
        @(negedge clk);
        root_ptr = 9'h000; feat_in = {8'd1, 8'd1, 8'd1}; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        chk("mid_mac_en", mac_en, 1);
        chk("mid_node_addr", node_addr, 8'h05);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_mac_en", mac_en, 0);
        chk("abort_node_addr", node_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run_walk(9'h000, {8'd1, 8'd1, 8'd1}, 1'b0, lat, n_en, n_clr, clr_cyc, first_en);
        chk("rewalk_lat", lat, 22);
        chk("rewalk_class", class_out, 9'h1AA);
        chk("rewalk_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
